// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stage registers:
//   STALL_W      width of the global stall vector
//   STG_*        bit index of each stage within the stall vector
//   occ_state_t  occupancy state of a stage register
//   stage_act_t  what a stage register does on a given clock edge
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int STALL_W = 6;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LIVE  = 2'd1,
        HELD  = 2'd2
    } occ_state_t;

    // Edge action, already resolved by priority (flush > bubble > hold > load)
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_FLUSH  = 2'd3
    } stage_act_t;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Width-parametrised up-counter that sticks at all-ones.
//   clk    clock
//   rst    asynchronous active-high reset (clears count)
//   clr    synchronous clear, wins over inc
//   inc    count enable
//   count  current value
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Inter-stage pipeline register with stall/bubble/flush handling and an
// occupancy FSM (EMPTY / LIVE / HELD).
//
// Optional feature macro: PIPE_STAGE_PERF_EN adds hold/bubble/flush counters.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   stall      global stall vector; bit STAGE_IDX freezes this stage,
//              bit STAGE_IDX+1 (if any) is the downstream stage
//   flush      discard contents, overrides any stall
//   in_valid   upstream valid
//   in_data    upstream payload
//   out_valid  registered valid
//   out_data   registered payload
//   out_held   registered, 1 while in HELD state
//   perf_clr         (PIPE_STAGE_PERF_EN) synchronous counter clear
//   perf_stall_cnt   (PIPE_STAGE_PERF_EN) hold edges, saturating
//   perf_bubble_cnt  (PIPE_STAGE_PERF_EN) bubble edges, saturating
//   perf_flush_cnt   (PIPE_STAGE_PERF_EN) flush edges, saturating
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                   PAYLOAD_W = 64,
    parameter logic [PAYLOAD_W-1:0] NOP_VALUE = '0,
    parameter int                   STALL_W   = pipe_pkg::STALL_W,
    parameter int                   STAGE_IDX = 1,
    parameter int                   CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic                 out_held
`ifdef PIPE_STAGE_PERF_EN
    ,
    input  logic                 perf_clr,
    output logic [CNT_W-1:0]     perf_stall_cnt,
    output logic [CNT_W-1:0]     perf_bubble_cnt,
    output logic [CNT_W-1:0]     perf_flush_cnt
`endif
);

    generate
        if (STAGE_IDX < 0 || STAGE_IDX >= STALL_W) begin : g_bad_idx
            $error("pipe_stage_reg: STAGE_IDX out of range 0..STALL_W-1");
        end
    endgenerate

    logic s_me;
    logic s_dn;

    assign s_me = stall[STAGE_IDX];

    // The last stage has no downstream neighbour, so it can never hold:
    // a stall on it always turns into a bubble.
    generate
        if (STAGE_IDX == STALL_W - 1) begin : g_last_stage
            assign s_dn = 1'b0;
        end else begin : g_mid_stage
            assign s_dn = stall[STAGE_IDX+1];
        end
    endgenerate

    // Only s_me / s_dn matter; the rest of the vector is intentionally dropped.
    logic unused_inputs;
    assign unused_inputs = ^{stall, (CNT_W != 0)};

    stage_act_t act;

    always_comb begin
        act = ACT_LOAD;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (s_me && !s_dn) begin
            act = ACT_BUBBLE;
        end else if (s_me) begin
            act = ACT_HOLD;
        end
    end

    // Payload / valid register
    logic                 valid_reg;
    logic [PAYLOAD_W-1:0] data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= NOP_VALUE;
        end else begin
            case (act)
                ACT_FLUSH, ACT_BUBBLE: begin
                    valid_reg <= 1'b0;
                    data_reg  <= NOP_VALUE;
                end
                ACT_HOLD: begin
                    valid_reg <= valid_reg;
                    data_reg  <= data_reg;
                end
                default: begin
                    // Payload is captured even when in_valid=0
                    valid_reg <= in_valid;
                    data_reg  <= in_data;
                end
            endcase
        end
    end

    // Occupancy FSM
    occ_state_t state_reg;
    occ_state_t state_next;
    logic       held_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
            held_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            held_reg  <= (state_next == HELD);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: begin
                if (act == ACT_LOAD && in_valid) begin
                    state_next = LIVE;
                end
            end
            LIVE, HELD: begin
                case (act)
                    ACT_FLUSH, ACT_BUBBLE: state_next = EMPTY;
                    ACT_HOLD:              state_next = HELD;
                    default:               state_next = in_valid ? LIVE : EMPTY;
                endcase
            end
            default: state_next = EMPTY;
        endcase
    end

    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    assign out_held  = held_reg;

`ifdef PIPE_STAGE_PERF_EN
    // Counter order: 0 = hold, 1 = bubble, 2 = flush
    logic [2:0]       perf_inc;
    logic [CNT_W-1:0] perf_cnt [3];

    assign perf_inc = {act == ACT_FLUSH, act == ACT_BUBBLE, act == ACT_HOLD};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_perf
            sat_counter #(
                .W(CNT_W)
            ) u_cnt (
                .clk  (clk),
                .rst  (rst),
                .clr  (perf_clr),
                .inc  (perf_inc[gi]),
                .count(perf_cnt[gi])
            );
        end
    endgenerate

    assign perf_stall_cnt  = perf_cnt[0];
    assign perf_bubble_cnt = perf_cnt[1];
    assign perf_flush_cnt  = perf_cnt[2];
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        perf_clr = 1'b0;

    always #5 clk = ~clk;

    logic        a_valid, b_valid, c_valid;
    logic        a_held, b_held, c_held;
    logic [63:0] a_data;
    logic [15:0] b_data, c_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] a_st, a_bu, a_fl;
    logic [1:0]  b_st, b_bu, b_fl, c_st, c_bu, c_fl;
`endif

    // a: IF/ID style stage 1, 64-bit; b: last stage (5); c: stage 2 with 2-bit counters
    pipe_stage_reg #(.PAYLOAD_W(64), .NOP_VALUE(64'h0), .STALL_W(6), .STAGE_IDX(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .out_valid(a_valid), .out_data(a_data), .out_held(a_held)
`ifdef PIPE_STAGE_PERF_EN
        , .perf_clr(perf_clr), .perf_stall_cnt(a_st), .perf_bubble_cnt(a_bu), .perf_flush_cnt(a_fl)
`endif
    );

    pipe_stage_reg #(.PAYLOAD_W(16), .NOP_VALUE(16'hA5A5), .STALL_W(6), .STAGE_IDX(5), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_data(in_data[15:0]), .out_valid(b_valid), .out_data(b_data), .out_held(b_held)
`ifdef PIPE_STAGE_PERF_EN
        , .perf_clr(perf_clr), .perf_stall_cnt(b_st), .perf_bubble_cnt(b_bu), .perf_flush_cnt(b_fl)
`endif
    );

    pipe_stage_reg #(.PAYLOAD_W(16), .NOP_VALUE(16'h1234), .STALL_W(6), .STAGE_IDX(2), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_data(in_data[15:0]), .out_valid(c_valid), .out_data(c_data), .out_held(c_held)
`ifdef PIPE_STAGE_PERF_EN
        , .perf_clr(perf_clr), .perf_stall_cnt(c_st), .perf_bubble_cnt(c_bu), .perf_flush_cnt(c_fl)
`endif
    );

    // Uniform views of the three instances
    logic        act_valid [3];
    logic        act_held  [3];
    logic [63:0] act_data  [3];
    assign act_valid[0] = a_valid; assign act_valid[1] = b_valid; assign act_valid[2] = c_valid;
    assign act_held[0]  = a_held;  assign act_held[1]  = b_held;  assign act_held[2]  = c_held;
    assign act_data[0]  = a_data;
    assign act_data[1]  = {48'h0, b_data};
    assign act_data[2]  = {48'h0, c_data};
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] act_st [3];
    logic [15:0] act_bu [3];
    logic [15:0] act_fl [3];
    assign act_st[0] = a_st; assign act_st[1] = {14'h0, b_st}; assign act_st[2] = {14'h0, c_st};
    assign act_bu[0] = a_bu; assign act_bu[1] = {14'h0, b_bu}; assign act_bu[2] = {14'h0, c_bu};
    assign act_fl[0] = a_fl; assign act_fl[1] = {14'h0, b_fl}; assign act_fl[2] = {14'h0, c_fl};
`endif

    // Behavioural model: per instance, what the outputs must be
    int          idx_m  [3] = '{1, 5, 2};
    logic [63:0] nop_m  [3] = '{64'h0, 64'hA5A5, 64'h1234};
    logic [63:0] mask_m [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF, 64'hFFFF};
    int          cmax_m [3] = '{65535, 3, 3};

    logic        exp_valid [3];
    logic        exp_held  [3];
    logic [63:0] exp_data  [3];
    int          exp_st [3];
    int          exp_bu [3];
    int          exp_fl [3];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                exp_valid[i] <= 1'b0;
                exp_held[i]  <= 1'b0;
                exp_data[i]  <= nop_m[i];
                exp_st[i] <= 0; exp_bu[i] <= 0; exp_fl[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                bit me, dn, is_fl, is_bu, is_ho;
                me    = stall[idx_m[i]];
                dn    = (idx_m[i] == 5) ? 1'b0 : stall[idx_m[i] + 1];
                is_fl = flush;
                is_bu = !flush && me && !dn;
                is_ho = !flush && me && dn;
                if (is_fl || is_bu) begin
                    exp_valid[i] <= 1'b0;
                    exp_data[i]  <= nop_m[i];
                end else if (!is_ho) begin
                    exp_valid[i] <= in_valid;
                    exp_data[i]  <= in_data & mask_m[i];
                end
                // HELD == a hold edge that kept a valid payload
                exp_held[i] <= is_ho && exp_valid[i];
                if (perf_clr) begin
                    exp_st[i] <= 0; exp_bu[i] <= 0; exp_fl[i] <= 0;
                end else begin
                    if (is_ho && exp_st[i] < cmax_m[i]) exp_st[i] <= exp_st[i] + 1;
                    if (is_bu && exp_bu[i] < cmax_m[i]) exp_bu[i] <= exp_bu[i] + 1;
                    if (is_fl && exp_fl[i] < cmax_m[i]) exp_fl[i] <= exp_fl[i] + 1;
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("dut%0d.out_valid", i), {63'h0, act_valid[i]}, {63'h0, exp_valid[i]});
                check($sformatf("dut%0d.out_data", i), act_data[i], exp_data[i]);
                check($sformatf("dut%0d.out_held", i), {63'h0, act_held[i]}, {63'h0, exp_held[i]});
`ifdef PIPE_STAGE_PERF_EN
                check($sformatf("dut%0d.perf_stall_cnt", i), {48'h0, act_st[i]}, 64'(exp_st[i]));
                check($sformatf("dut%0d.perf_bubble_cnt", i), {48'h0, act_bu[i]}, 64'(exp_bu[i]));
                check($sformatf("dut%0d.perf_flush_cnt", i), {48'h0, act_fl[i]}, 64'(exp_fl[i]));
`endif
            end
        end
    end

    typedef struct {
        logic [5:0]  st;
        logic        fl;
        logic        iv;
        logic        clr;
        logic [63:0] d;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV] = '{
        '{6'b000000, 1'b0, 1'b1, 1'b0, 64'h00400000_8C010004},  // 0 load
        '{6'b001110, 1'b0, 1'b1, 1'b0, 64'h11111111_11111111},  // 1 hold a,c
        '{6'b001110, 1'b0, 1'b1, 1'b0, 64'h22222222_22222222},  // 2 hold
        '{6'b001110, 1'b0, 1'b0, 1'b0, 64'h33333333_33333333},  // 3 hold
        '{6'b000000, 1'b0, 1'b1, 1'b0, 64'h00400004_AC020008},  // 4 load
        '{6'b000010, 1'b0, 1'b1, 1'b0, 64'h55555555_55555555},  // 5 bubble a
        '{6'b000000, 1'b0, 1'b1, 1'b0, 64'h66666666_66666666},  // 6 load
        '{6'b001110, 1'b1, 1'b1, 1'b0, 64'h77777777_77777777},  // 7 flush + stall
        '{6'b000000, 1'b0, 1'b1, 1'b0, 64'h0040000C_8C030010},  // 8 resume
        '{6'b000000, 1'b0, 1'b0, 1'b0, 64'h99999999_99999999},  // 9 invalid payload
        '{6'b001110, 1'b0, 1'b1, 1'b0, 64'hAAAAAAAA_AAAAAAAA},  // 10 hold while empty
        '{6'b000000, 1'b0, 1'b1, 1'b0, 64'hBBBBBBBB_BBBBBBBB},  // 11 load
        '{6'b100000, 1'b0, 1'b1, 1'b1, 64'hCCCCCCCC_CCCCCCCC},  // 12 b bubble, clear counters
        '{6'b111111, 1'b0, 1'b1, 1'b0, 64'hDDDDDDDD_DDDDDDDD},  // 13 a,c hold; b bubble
        '{6'b001100, 1'b0, 1'b1, 1'b0, 64'hE0E0E0E0_E0E0E0E0},  // 14 c hold, a load
        '{6'b001100, 1'b0, 1'b1, 1'b0, 64'hE1E1E1E1_E1E1E1E1},  // 15
        '{6'b001100, 1'b0, 1'b1, 1'b0, 64'hE2E2E2E2_E2E2E2E2},  // 16
        '{6'b001100, 1'b0, 1'b1, 1'b0, 64'hE3E3E3E3_E3E3E3E3},  // 17 c: 5th hold
        '{6'b001100, 1'b0, 1'b1, 1'b0, 64'hE4E4E4E4_E4E4E4E4},  // 18 c: 6th hold
        '{6'b001100, 1'b0, 1'b1, 1'b1, 64'hF0F0F0F0_F0F0F0F0},  // 19 clear beats hold
        '{6'b000000, 1'b0, 1'b1, 1'b0, 64'h12345678_9ABCDEF0},  // 20 load
        '{6'b000001, 1'b0, 1'b1, 1'b0, 64'h0FEDCBA9_87654321}   // 21 unrelated bit ignored
    };

    // Hand-computed pins on the model's key points
    task automatic pin_checks(input int k);
        case (k)
            0: begin
                check("load.a_data", a_data, 64'h00400000_8C010004);
                check("load.a_valid", {63'h0, a_valid}, 64'd1);
                check("load.a_held", {63'h0, a_held}, 64'd0);
            end
            3: begin
                check("hold.a_data", a_data, 64'h00400000_8C010004);
                check("hold.a_held", {63'h0, a_held}, 64'd1);
`ifdef PIPE_STAGE_PERF_EN
                check("hold.a_stall_cnt", {48'h0, a_st}, 64'd3);
`endif
            end
            5: begin
                check("bubble.a_data", a_data, 64'h0);
                check("bubble.a_valid", {63'h0, a_valid}, 64'd0);
`ifdef PIPE_STAGE_PERF_EN
                check("bubble.a_bubble_cnt", {48'h0, a_bu}, 64'd1);
`endif
            end
            7: begin
                check("flush.a_valid", {63'h0, a_valid}, 64'd0);
                check("flush.a_data", a_data, 64'h0);
            end
            8: begin
                check("resume.a_data", a_data, 64'h0040000C_8C030010);
                check("resume.a_valid", {63'h0, a_valid}, 64'd1);
            end
            12: begin
                check("last.b_data", {48'h0, b_data}, 64'hA5A5);
                check("last.b_valid", {63'h0, b_valid}, 64'd0);
            end
            17: begin
                check("sat.c_held", {63'h0, c_held}, 64'd1);
                check("sat.c_data", {48'h0, c_data}, 64'hCCCC);
`ifdef PIPE_STAGE_PERF_EN
                check("sat.c_stall_cnt", {48'h0, c_st}, 64'd3);
`endif
            end
`ifdef PIPE_STAGE_PERF_EN
            19: check("clr.c_stall_cnt", {48'h0, c_st}, 64'd0);
`endif
            default: ;
        endcase
    endtask

    initial begin
        #1 rst = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            stall    = vecs[k].st;
            flush    = vecs[k].fl;
            in_valid = vecs[k].iv;
            perf_clr = vecs[k].clr;
            in_data  = vecs[k].d;
            @(posedge clk);
            #1;
            $display("vec %0d: stall=%b flush=%b iv=%b a=%0h/%0b b=%0h/%0b c=%0h/%0b",
                     k, vecs[k].st, vecs[k].fl, vecs[k].iv, a_data, a_valid, b_data, b_valid, c_data, c_valid);
            pin_checks(k);
        end

        // Asynchronous reset in the middle of a cycle
        @(negedge clk);
        stall = 6'b000000; flush = 1'b0; perf_clr = 1'b0;
        in_valid = 1'b1; in_data = 64'hDEADBEEF_DEADBEEF;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst.a_data", a_data, 64'h0);
        check("arst.a_valid", {63'h0, a_valid}, 64'd0);
        check("arst.a_held", {63'h0, a_held}, 64'd0);
        check("arst.b_data", {48'h0, b_data}, 64'hA5A5);
`ifdef PIPE_STAGE_PERF_EN
        check("arst.a_stall_cnt", {48'h0, a_st}, 64'd0);
`endif
        $display("arst: a=%0h/%0b b=%0h/%0b", a_data, a_valid, b_data, b_valid);

        // Release reset while stalled: must stay EMPTY
        @(negedge clk);
        stall = 6'b001110;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("arst_stall.a_valid", {63'h0, a_valid}, 64'd0);
        check("arst_stall.a_held", {63'h0, a_held}, 64'd0);
        $display("arst_stall: a=%0h/%0b held=%0b", a_data, a_valid, a_held);

        @(negedge clk);
        stall = 6'b000000; in_data = 64'h00400010_00000013;
        @(posedge clk);
        #1;
        check("final.a_data", a_data, 64'h00400010_00000013);
        $display("final: a=%0h/%0b", a_data, a_valid);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
